// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard signals between the pipelined controller/datapath and the hazard unit.
interface hazard_ctrl_if;
  logic [3:0] RA1D, RA2D, RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW;
  logic       MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit: forwarding, load-use stall, redirect flushes, debug-halt drain
// handshake and saturating hazard performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             halt_ack,
  output logic [CNT_W-1:0] ldstall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] pcwait_cnt
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam int unsigned  DW   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] LAST = DW'(DRAIN_CYC - 1);

  logic [1:0]    state;
  logic [DW-1:0] dcnt;
  logic          ldstall;

  // R15 reads the PC, so it is never a forwarding target.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic [3:0] wm,
                                         input logic [3:0] ww, input logic rwm,
                                         input logic rww);
    if (ra == 4'd15)            return 2'b00;
    else if (rwm && (ra == wm)) return 2'b10;
    else if (rww && (ra == ww)) return 2'b01;
    else                        return 2'b00;
  endfunction

  always_comb begin
    hz.ForwardAE = fwd_sel(hz.RA1E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
    hz.ForwardBE = fwd_sel(hz.RA2E, hz.WA3M, hz.WA3W, hz.RegWriteM, hz.RegWriteW);
  end

  assign ldstall = hz.MemtoRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));

  always_comb begin
    hz.StallD = ldstall;
    hz.StallF = ldstall | hz.PCWrPendingF;
    hz.FlushD = hz.PCWrPendingF | hz.PCSrcW | hz.BranchTakenE;
    hz.FlushE = ldstall | hz.BranchTakenE;
    if (state != RUN) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
      hz.FlushD = 1'b0;
    end
  end

  assign halt_ack = (state == HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          // Halt waits until any redirect has been taken so it never splits one.
          if (halt_req && !hz.PCWrPendingF && !hz.BranchTakenE)
            state <= DRAIN;
        end
        DRAIN: begin
          if (dcnt == LAST) begin
            state <= HALTED;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  logic ld_inc, fl_inc, pw_inc;
  assign ld_inc = (state == RUN) && ldstall;
  assign fl_inc = (state == RUN) && hz.BranchTakenE;
  assign pw_inc = hz.PCWrPendingF && !ldstall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldstall_cnt <= '0;
      flush_cnt   <= '0;
      pcwait_cnt  <= '0;
    end else if (cnt_clr) begin
      ldstall_cnt <= '0;
      flush_cnt   <= '0;
      pcwait_cnt  <= '0;
    end else begin
      if (ld_inc && !(&ldstall_cnt)) ldstall_cnt <= ldstall_cnt + 1'b1;
      if (fl_inc && !(&flush_cnt))   flush_cnt   <= flush_cnt + 1'b1;
      if (pw_inc && !(&pcwait_cnt))  pcwait_cnt  <= pcwait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl, built with 4-bit counters.
module tb_hazard_ctrl;
  logic       clk;
  logic       reset;
  logic       halt_req;
  logic       cnt_clr;
  logic       halt_ack;
  logic [3:0] ldstall_cnt, flush_cnt, pcwait_cnt;
  int         checks;
  int         failures;

  hazard_ctrl_if hz();

  hazard_ctrl #(.CNT_W(4), .DRAIN_CYC(3)) dut (
    .clk(clk), .reset(reset), .hz(hz), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .halt_ack(halt_ack), .ldstall_cnt(ldstall_cnt), .flush_cnt(flush_cnt),
    .pcwait_cnt(pcwait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    hz.RA1D = '0; hz.RA2D = '0; hz.RA1E = '0; hz.RA2E = '0;
    hz.WA3E = '0; hz.WA3M = '0; hz.WA3W = '0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.MemtoRegE = 1'b0;
    hz.BranchTakenE = 1'b0; hz.PCWrPendingF = 1'b0; hz.PCSrcW = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; halt_req = 1'b0; cnt_clr = 1'b0;
    clr_inputs();
    #1 reset = 1'b0;
    #2;
    check("rst_ack", halt_ack, 0);
    check("rst_ldcnt", ldstall_cnt, 0);
    check("rst_flcnt", flush_cnt, 0);
    check("rst_pwcnt", pcwait_cnt, 0);
    check("rst_stallf", hz.StallF, 0);
    check("rst_fwda", hz.ForwardAE, 0);
    #10 reset = 1'b1;
    step();

    // forwarding priority
    hz.RA1E = 4'd3; hz.WA3M = 4'd3; hz.RegWriteM = 1'b1; hz.WA3W = 4'd3; hz.RegWriteW = 1'b1;
    #1 check("fwd_m", hz.ForwardAE, 2'b10);
    hz.RegWriteM = 1'b0;
    #1 check("fwd_w", hz.ForwardAE, 2'b01);
    hz.RA1E = 4'd15; hz.WA3M = 4'd15; hz.WA3W = 4'd15; hz.RegWriteM = 1'b1;
    #1 check("fwd_r15", hz.ForwardAE, 2'b00);
    hz.RA2E = 4'd7; hz.WA3W = 4'd7; hz.WA3M = 4'd4;
    #1 check("fwd_b_w", hz.ForwardBE, 2'b01);
    clr_inputs();

    // load-use stall
    hz.MemtoRegE = 1'b1; hz.WA3E = 4'd5; hz.RA2D = 4'd5; hz.RA1D = 4'd1;
    #1;
    check("lu_stallf", hz.StallF, 1);
    check("lu_stalld", hz.StallD, 1);
    check("lu_flushe", hz.FlushE, 1);
    check("lu_flushd", hz.FlushD, 0);
    repeat (3) step();
    check("lu_cnt3", ldstall_cnt, 3);
    check("lu_pwcnt", pcwait_cnt, 0);
    clr_inputs();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("lu_clr", ldstall_cnt, 0);

    // PC write in flight, then retiring
    hz.PCWrPendingF = 1'b1;
    #1;
    check("pc_stallf1", hz.StallF, 1);
    check("pc_flushd1", hz.FlushD, 1);
    check("pc_stalld1", hz.StallD, 0);
    check("pc_flushe1", hz.FlushE, 0);
    step();
    check("pc_stallf2", hz.StallF, 1);
    check("pc_flushd2", hz.FlushD, 1);
    step();
    check("pc_stallf3", hz.StallF, 1);
    check("pc_flushd3", hz.FlushD, 1);
    step();
    hz.PCWrPendingF = 1'b0; hz.PCSrcW = 1'b1;
    #1;
    check("pc_flushd4", hz.FlushD, 1);
    check("pc_stallf4", hz.StallF, 0);
    check("pc_cnt3", pcwait_cnt, 3);
    step();
    check("pc_cnt_hold", pcwait_cnt, 3);
    clr_inputs();

    // halt handshake
    halt_req = 1'b1;
    #1;
    check("h_run_ack", halt_ack, 0);
    check("h_run_stallf", hz.StallF, 0);
    step();
    check("h_d0_stallf", hz.StallF, 1);
    check("h_d0_stalld", hz.StallD, 1);
    check("h_d0_flushe", hz.FlushE, 1);
    check("h_d0_flushd", hz.FlushD, 0);
    check("h_d0_ack", halt_ack, 0);
    hz.RA1E = 4'd3; hz.WA3M = 4'd3; hz.RegWriteM = 1'b1;
    #1 check("h_d0_fwd", hz.ForwardAE, 2'b10);
    step();
    check("h_d1_ack", halt_ack, 0);
    check("h_d1_stallf", hz.StallF, 1);
    step();
    check("h_d2_ack", halt_ack, 0);
    check("h_d2_stallf", hz.StallF, 1);
    step();
    check("h_halt_ack", halt_ack, 1);
    check("h_halt_stallf", hz.StallF, 1);
    check("h_halt_flushe", hz.FlushE, 1);
    step();
    check("h_halt_hold", halt_ack, 1);
    halt_req = 1'b0;
    #1 check("h_rel_same", halt_ack, 1);
    step();
    check("h_rel_ack", halt_ack, 0);
    check("h_rel_stallf", hz.StallF, 0);
    clr_inputs();

    // halt_req drops mid-drain: drain completes, ack pulses once
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    step();
    step();
    check("hd_drain_ack", halt_ack, 0);
    step();
    check("hd_pulse", halt_ack, 1);
    step();
    check("hd_pulse_end", halt_ack, 0);

    // halt deferred behind a taken branch
    halt_req = 1'b1; hz.BranchTakenE = 1'b1;
    #1;
    check("df_flushd", hz.FlushD, 1);
    check("df_flushe", hz.FlushE, 1);
    check("df_stallf", hz.StallF, 0);
    step();
    hz.BranchTakenE = 1'b0;
    #1;
    check("df_still_run", hz.StallF, 0);
    check("df_flcnt", flush_cnt, 1);
    step();
    check("df_drain", hz.StallF, 1);
    halt_req = 1'b0;
    repeat (3) step();
    check("df_ack", halt_ack, 1);
    step();
    check("df_run", halt_ack, 0);

    // load-use and branch together
    hz.MemtoRegE = 1'b1; hz.WA3E = 4'd5; hz.RA2D = 4'd5; hz.BranchTakenE = 1'b1;
    #1;
    check("both_stallf", hz.StallF, 1);
    check("both_stalld", hz.StallD, 1);
    check("both_flushd", hz.FlushD, 1);
    check("both_flushe", hz.FlushE, 1);
    clr_inputs();

    // saturation and clear priority
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    hz.MemtoRegE = 1'b1; hz.WA3E = 4'd5; hz.RA1D = 4'd5;
    repeat (20) step();
    check("sat_15", ldstall_cnt, 15);
    cnt_clr = 1'b1;
    step();
    check("sat_clr", ldstall_cnt, 0);
    cnt_clr = 1'b0;
    step();
    check("sat_inc1", ldstall_cnt, 1);
    clr_inputs();

    // async reset during drain
    halt_req = 1'b1;
    step();
    step();
    check("ar_in_drain", hz.StallF, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_ack", halt_ack, 0);
    check("ar_stallf", hz.StallF, 0);
    check("ar_ldcnt", ldstall_cnt, 0);
    halt_req = 1'b0;
    #2 reset = 1'b1;
    step();
    check("ar_run_ack", halt_ack, 0);
    check("ar_run_stallf", hz.StallF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
